muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
Multi-cycle execution controller for the RV32M instructions flagged by the decoder one-hots (mul, mulh, mulhsu, mulhu, div, divu, rem, remu).
- Latches operands on a valid/ready handshake.
- Runs an iterative shift-add multiply or restoring divide over XLEN cycles.
- Holds the execute stage busy while running, then returns one result with a single-cycle out_valid pulse.
- Sits in the execute stage beside the ALU; hazard logic stalls upstream while busy=1.

Parameters:
XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  request valid
in_ready  output  1  block can accept a request (state IDLE)
op_onehot  input  8  [0]mul [1]mulh [2]mulhsu [3]mulhu [4]div [5]divu [6]rem [7]remu
rs1_val  input  XLEN  operand A / dividend
rs2_val  input  XLEN  operand B / divisor
flush  input  1  synchronous abort (pipeline flush)
busy  output  1  operation in flight (state != IDLE)
out_valid  output  1  one-cycle pulse, result valid
result  output  XLEN  result, held until next out_valid

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, named rst_n.
- Reset values: state=IDLE, out_valid=0, busy=0, result=0, all internal registers 0. in_ready=1 as soon as rst_n is low.
- Accept:
  - Accept occurs in cycle N when in_valid && in_ready && op_onehot is exactly one-hot && !flush.
  - An op_onehot that is zero or has multiple bits set is ignored: no accept, state stays IDLE.
  - At accept, operands and op are latched. Later input changes have no effect.
- FSM states: IDLE, RUN, FIX, DONE.
  - IDLE -> RUN on accept (normal case).
  - IDLE -> DONE on accept of a special-case op.
  - RUN: one iteration per cycle. The counter counts XLEN-1 down to 0; at 0 -> FIX.
  - FIX: apply sign correction and select the result half/part -> DONE.
  - DONE: out_valid=1 for exactly one cycle, result registered -> IDLE.
- Latency:
  - Normal case: out_valid in cycle N+XLEN+2 (N+34 for XLEN=32).
  - Special cases: out_valid in cycle N+1.
  - in_ready is 0 from N+1 until the DONE cycle inclusive. A new accept is possible the cycle after DONE.
- Multiply:
  - Operates on magnitudes: rs1 is signed for mulh/mulhsu; rs2 is signed for mulh only.
  - 2*XLEN-bit product accumulated by shift-add, then negated in FIX if the operand signs differ.
  - mul returns product[XLEN-1:0]. mulh, mulhsu and mulhu return product[2*XLEN-1:XLEN].
- Divide:
  - Restoring divide on magnitudes; signed for div/rem.
  - Quotient is negated if the signs differ. Remainder takes the dividend's sign.
- Special cases (no iteration, resolved at accept):
  - Divisor=0: quotient = all ones, remainder = dividend, for both signed and unsigned.
  - Signed overflow (dividend = 0x80000000, divisor = -1): quotient = 0x80000000, remainder = 0.
- flush:
  - In any non-IDLE state, the state returns to IDLE next cycle with no out_valid; result keeps its old value.
  - flush in the same cycle as in_valid blocks the accept.
  - flush in the DONE cycle does not suppress that cycle's out_valid.
- Reset mid-operation: aborts immediately; all outputs take their reset values asynchronously.
- Widths: all intermediate arithmetic is XLEN+1 (divide) or 2*XLEN (multiply) bits; no truncation until FIX.

Optional Feature:
MULDIV_FAST_MUL_EN:
- Defined: multiply ops use a single-cycle signed-extended (XLEN+1)x(XLEN+1) multiplier. Path is IDLE -> DONE with out_valid at N+1. Divide timing is unchanged.
- Undefined: multiply uses the iterative path with out_valid at N+XLEN+2.
- Results are identical in both builds.

Test Plan:
- mul 7 x 0xFFFFFFFD (-3), accept at N -> out_valid at N+34 (N+1 with MULDIV_FAST_MUL_EN), result=0xFFFFFFEB. in_ready=0 from N+1 through N+34.
- mulh 0x80000000 x 0x80000000 -> 0x40000000. mulhu 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. mulhsu 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- div 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD. rem -> 0xFFFFFFFF. divu 100/7 -> 0x0000000E. remu 100/7 -> 0x00000002. Each at N+34.
- div 5/0 -> 0xFFFFFFFF at N+1. rem 5/0 -> 0x00000005. div 0x80000000/0xFFFFFFFF -> 0x80000000. rem of the same -> 0x00000000. All at N+1.
- flush at N+10 of a divu -> no out_valid ever, busy=0 and in_ready=1 at N+11. Then mul 3x4 -> 0x0000000C. Also: op_onehot=0x03 with in_valid -> no accept, busy stays 0.
- rst_n low at N+5 -> busy=0, out_valid=0, result=0 without waiting for a clk edge. After release, divu 9/3 -> 0x00000003.

Source files
------------

// File: rtl/muldiv_sequencer_if.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer_if
// Request/response bundle between the execute stage and the RV32M multi-cycle
// multiply/divide sequencer.
//
// Signals:
//   in_valid   request valid (master -> slave)
//   in_ready   sequencer idle and able to accept (slave -> master)
//   op_onehot  [0]mul [1]mulh [2]mulhsu [3]mulhu [4]div [5]divu [6]rem [7]remu
//   rs1_val    operand A / dividend
//   rs2_val    operand B / divisor
//   flush      synchronous pipeline abort
//   busy       operation in flight
//   out_valid  one-cycle result pulse
//   result     result value, held until the next out_valid
//
// Modports: master (execute stage / testbench), slave (sequencer).
// -----------------------------------------------------------------------------
interface muldiv_sequencer_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [7:0]      op_onehot;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic            flush;
  logic            busy;
  logic            out_valid;
  logic [XLEN-1:0] result;

  modport master (
    output in_valid, op_onehot, rs1_val, rs2_val, flush,
    input  in_ready, busy, out_valid, result
  );

  modport slave (
    input  in_valid, op_onehot, rs1_val, rs2_val, flush,
    output in_ready, busy, out_valid, result
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer
// Multi-cycle execution controller for the RV32M multiply/divide instructions.
// A request is latched on the in_valid/in_ready handshake; the block then runs
// an iterative shift-add multiply or restoring divide on operand magnitudes
// for XLEN cycles, fixes the sign and picks the result part, and returns the
// result with a single-cycle out_valid pulse. Divide-by-zero and signed
// overflow are resolved at accept time and skip the iteration.
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    muldiv_sequencer_if.slave (handshake, operands, flush, result)
//
// Optional build macro:
//   MULDIV_FAST_MUL_EN  multiply ops use a single-cycle sign-extended
//                       multiplier (IDLE -> DONE); divide timing unchanged.
// -----------------------------------------------------------------------------
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  muldiv_sequencer_if.slave  bus
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        op_q, op_d;
  logic [XLEN-1:0]   opA_q, opA_d;
  logic [XLEN-1:0]   opB_q, opB_d;
  logic              negQ_q, negQ_d;
  logic              negR_q, negR_d;
  logic [2*XLEN-1:0] mulAcc_q, mulAcc_d;
  logic [XLEN-1:0]   divRem_q, divRem_d;
  logic [XLEN-1:0]   divQuo_q, divQuo_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   result_q, result_d;

  // Request decode: sign handling, magnitudes and the special divide cases
  // are all derived from the live inputs so they can be latched at accept.
  logic [7:0]      opIn;
  logic            oneHot;
  logic            accept;
  logic            sgnA, sgnB, negA, negB;
  logic [XLEN-1:0] magA, magB;
  logic            isDivIn, divZero, divOvf, special;
  logic [XLEN-1:0] specialRes;

  always_comb begin
    opIn       = bus.op_onehot;
    oneHot     = (opIn != 8'd0) && ((opIn & (opIn - 8'd1)) == 8'd0);
    accept     = bus.in_valid && (state_q == IDLE) && oneHot && !bus.flush;
    sgnA       = opIn[1] | opIn[2] | opIn[4] | opIn[6];
    sgnB       = opIn[1] | opIn[4] | opIn[6];
    negA       = sgnA & bus.rs1_val[XLEN-1];
    negB       = sgnB & bus.rs2_val[XLEN-1];
    magA       = negA ? -bus.rs1_val : bus.rs1_val;
    magB       = negB ? -bus.rs2_val : bus.rs2_val;
    isDivIn    = |opIn[7:4];
    divZero    = (bus.rs2_val == '0);
    divOvf     = (opIn[4] | opIn[6]) && (bus.rs1_val == MIN_NEG) && (bus.rs2_val == '1);
    special    = isDivIn && (divZero || divOvf);
    if (opIn[4] | opIn[5]) begin
      specialRes = divZero ? '1 : MIN_NEG;
    end else begin
      specialRes = divZero ? bus.rs1_val : '0;
    end
  end

`ifdef MULDIV_FAST_MUL_EN
  // Single-cycle multiplier: operands sign-extended to 2*XLEN bits so the
  // modulo-2^(2*XLEN) product matches the iterative result for every variant.
  logic              fastMul;
  logic [2*XLEN-1:0] fastA, fastB, fastP;
  logic [XLEN-1:0]   fastRes;

  always_comb begin
    fastMul = |opIn[3:0];
    fastA   = {{XLEN{negA}}, bus.rs1_val};
    fastB   = {{XLEN{negB}}, bus.rs2_val};
    fastP   = fastA * fastB;
    fastRes = opIn[0] ? fastP[XLEN-1:0] : fastP[2*XLEN-1:XLEN];
  end
`endif

  // One iteration of each datapath. Multiply adds the multiplicand into the
  // upper half when the current multiplier bit is set, then shifts right.
  // Divide shifts in the next dividend bit and keeps the trial subtraction
  // only when it does not go negative.
  logic [XLEN:0]     mulSum;
  logic [XLEN:0]     divShift, divDiff;
  logic [2*XLEN-1:0] prodFinal;
  logic [XLEN-1:0]   quoFinal, remFinal, fixRes;

  always_comb begin
    mulSum    = {1'b0, mulAcc_q[2*XLEN-1:XLEN]} + {1'b0, opA_q};
    divShift  = {divRem_q, divQuo_q[XLEN-1]};
    divDiff   = divShift - {1'b0, opB_q};
    prodFinal = negQ_q ? -mulAcc_q : mulAcc_q;
    quoFinal  = negQ_q ? -divQuo_q : divQuo_q;
    remFinal  = negR_q ? -divRem_q : divRem_q;
    if (op_q[0]) begin
      fixRes = prodFinal[XLEN-1:0];
    end else if (|op_q[3:1]) begin
      fixRes = prodFinal[2*XLEN-1:XLEN];
    end else if (|op_q[5:4]) begin
      fixRes = quoFinal;
    end else if (|op_q[7:6]) begin
      fixRes = remFinal;
    end else begin
      fixRes = '0;
    end
  end

  // Next-state and datapath control. Every register holds by default; flush
  // in any busy state drops straight back to IDLE without touching result,
  // while DONE always returns to IDLE so its out_valid is never suppressed.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    opA_d    = opA_q;
    opB_d    = opB_q;
    negQ_d   = negQ_q;
    negR_d   = negR_q;
    mulAcc_d = mulAcc_q;
    divRem_d = divRem_q;
    divQuo_d = divQuo_q;
    cnt_d    = cnt_q;
    result_d = result_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d     = opIn;
          opA_d    = magA;
          opB_d    = magB;
          negQ_d   = negA ^ negB;
          negR_d   = negA;
          mulAcc_d = {{XLEN{1'b0}}, magB};
          divRem_d = '0;
          divQuo_d = magA;
          cnt_d    = CNT_W'(XLEN - 1);
          if (special) begin
            result_d = specialRes;
            state_d  = DONE;
          end
`ifdef MULDIV_FAST_MUL_EN
          else if (fastMul) begin
            result_d = fastRes;
            state_d  = DONE;
          end
`endif
          else begin
            state_d = RUN;
          end
        end
      end

      RUN: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else begin
          if (|op_q[3:0]) begin
            mulAcc_d = mulAcc_q[0] ? {mulSum, mulAcc_q[XLEN-1:1]}
                                   : {1'b0, mulAcc_q[2*XLEN-1:1]};
          end else begin
            divRem_d = divDiff[XLEN] ? divShift[XLEN-1:0] : divDiff[XLEN-1:0];
            divQuo_d = {divQuo_q[XLEN-2:0], ~divDiff[XLEN]};
          end
          if (cnt_q == '0) begin
            state_d = FIX;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end

      FIX: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else begin
          result_d = fixRes;
          state_d  = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers, all cleared asynchronously by rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= '0;
      opA_q    <= '0;
      opB_q    <= '0;
      negQ_q   <= 1'b0;
      negR_q   <= 1'b0;
      mulAcc_q <= '0;
      divRem_q <= '0;
      divQuo_q <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      opA_q    <= opA_d;
      opB_q    <= opB_d;
      negQ_q   <= negQ_d;
      negR_q   <= negR_d;
      mulAcc_q <= mulAcc_d;
      divRem_q <= divRem_d;
      divQuo_q <= divQuo_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  // Status outputs decode straight from the state register so they follow
  // rst_n asynchronously.
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// tb_muldiv_sequencer
// Self-checking bench for muldiv_sequencer. Expected results and latencies are
// pushed to a scoreboard queue when a request is driven and popped when the
// sequencer pulses out_valid.
// -----------------------------------------------------------------------------
module tb_muldiv_sequencer;

  localparam int XLEN = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 34;
`endif
  localparam int DIV_LAT  = 34;
  localparam int SPEC_LAT = 1;

  localparam logic [7:0] OP_MUL    = 8'h01;
  localparam logic [7:0] OP_MULH   = 8'h02;
  localparam logic [7:0] OP_MULHSU = 8'h04;
  localparam logic [7:0] OP_MULHU  = 8'h08;
  localparam logic [7:0] OP_DIV    = 8'h10;
  localparam logic [7:0] OP_DIVU   = 8'h20;
  localparam logic [7:0] OP_REM    = 8'h40;
  localparam logic [7:0] OP_REMU   = 8'h80;

  typedef struct {
    logic [31:0] res;
    int          lat;
    string       tag;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [31:0] lastResult;
  exp_t sb[$];

  muldiv_sequencer_if #(.XLEN(XLEN)) bus ();

  muldiv_sequencer #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net in case the DUT wedges the bench somewhere unexpected.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Independent reference for the random requests, using native 64-bit ops.
  function automatic void refModel(input int k, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] r, output int lat);
    longint sa, sb2, ua, ub, q;
    logic [63:0] p;
    sa  = longint'($signed(a));
    sb2 = longint'($signed(b));
    ua  = longint'({32'h0, a});
    ub  = longint'({32'h0, b});
    r   = '0;
    lat = DIV_LAT;
    case (k)
      0: begin p = ua * ub;  r = p[31:0];  lat = MUL_LAT; end
      1: begin p = sa * sb2; r = p[63:32]; lat = MUL_LAT; end
      2: begin p = sa * ub;  r = p[63:32]; lat = MUL_LAT; end
      3: begin p = ua * ub;  r = p[63:32]; lat = MUL_LAT; end
      4: begin
        if (b == 32'h0) begin r = 32'hFFFF_FFFF; lat = SPEC_LAT; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin r = 32'h8000_0000; lat = SPEC_LAT; end
        else begin q = sa / sb2; p = q; r = p[31:0]; end
      end
      5: begin
        if (b == 32'h0) begin r = 32'hFFFF_FFFF; lat = SPEC_LAT; end
        else begin q = ua / ub; p = q; r = p[31:0]; end
      end
      6: begin
        if (b == 32'h0) begin r = a; lat = SPEC_LAT; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin r = 32'h0; lat = SPEC_LAT; end
        else begin q = sa % sb2; p = q; r = p[31:0]; end
      end
      default: begin
        if (b == 32'h0) begin r = a; lat = SPEC_LAT; end
        else begin q = ua % ub; p = q; r = p[31:0]; end
      end
    endcase
  endfunction

  // Drive one request through the accept edge, then scramble the operand
  // inputs so any late sampling by the DUT shows up as a wrong result.
  // Entered and left at 1 ns after a rising edge.
  task automatic acceptOnly(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.in_valid  = 1'b1;
    bus.op_onehot = op;
    bus.rs1_val   = a;
    bus.rs2_val   = b;
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.op_onehot = 8'($urandom);
    bus.rs1_val   = $urandom;
    bus.rs2_val   = $urandom;
  endtask

  task automatic applyStimulus(input string tag, input logic [7:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] expRes, input int expLat);
    exp_t e;
    e.res = expRes;
    e.lat = expLat;
    e.tag = tag;
    sb.push_back(e);
    acceptOnly(op, a, b);
  endtask

  // Wait (bounded) for out_valid, then check latency, result, in_ready and
  // that the pulse lasts exactly one cycle with the result held afterwards.
  task automatic checkOutput();
    exp_t e;
    int   cyc;
    bit   readyBad;
    if (sb.size() == 0) begin
      checkVal("scoreboard-empty", 32'd0, 32'd1);
      return;
    end
    e        = sb.pop_front();
    cyc      = 1;
    readyBad = 1'b0;
    while (bus.out_valid !== 1'b1 && cyc < 100) begin
      if (bus.in_ready !== 1'b0) readyBad = 1'b1;
      @(posedge clk);
      #1;
      cyc++;
    end
    checkVal({e.tag, "/ready-low"}, 32'(readyBad), 32'd0);
    checkVal({e.tag, "/latency"}, 32'(cyc), 32'(e.lat));
    checkVal({e.tag, "/out_valid"}, 32'(bus.out_valid), 32'd1);
    checkVal({e.tag, "/result"}, bus.result, e.res);
    checkVal({e.tag, "/ready-done"}, 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1;
    checkVal({e.tag, "/pulse-end"}, 32'(bus.out_valid), 32'd0);
    checkVal({e.tag, "/ready-after"}, 32'(bus.in_ready), 32'd1);
    checkVal({e.tag, "/held"}, bus.result, e.res);
    lastResult = e.res;
  endtask

  initial begin
    int          seen;
    int          k;
    int          lat;
    logic [31:0] a, b, r;

    checks        = 0;
    errors        = 0;
    lastResult    = '0;
    rst_n         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.op_onehot = 8'h00;
    bus.rs1_val   = '0;
    bus.rs2_val   = '0;
    bus.flush     = 1'b0;

    // Reset state is visible while rst_n is low, before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    checkVal("reset/in_ready", 32'(bus.in_ready), 32'd1);
    checkVal("reset/busy", 32'(bus.busy), 32'd0);
    checkVal("reset/out_valid", 32'(bus.out_valid), 32'd0);
    checkVal("reset/result", bus.result, 32'h0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed multiplies.
    applyStimulus("mul7x-3", OP_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT);
    checkOutput();
    applyStimulus("mulh", OP_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT);
    checkOutput();
    applyStimulus("mulhu", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
    checkOutput();
    applyStimulus("mulhsu", OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT);
    checkOutput();

    // Directed divides.
    applyStimulus("div-7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, DIV_LAT);
    checkOutput();
    applyStimulus("rem-7/2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, DIV_LAT);
    checkOutput();
    applyStimulus("divu100/7", OP_DIVU, 32'd100, 32'd7, 32'h0000_000E, DIV_LAT);
    checkOutput();
    applyStimulus("remu100/7", OP_REMU, 32'd100, 32'd7, 32'h0000_0002, DIV_LAT);
    checkOutput();

    // Special cases resolved at accept.
    applyStimulus("div5/0", OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, SPEC_LAT);
    checkOutput();
    applyStimulus("rem5/0", OP_REM, 32'd5, 32'd0, 32'h0000_0005, SPEC_LAT);
    checkOutput();
    applyStimulus("divovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPEC_LAT);
    checkOutput();
    applyStimulus("removf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, SPEC_LAT);
    checkOutput();

    // flush during DONE must not suppress that cycle's out_valid.
    applyStimulus("divu0-doneflush", OP_DIVU, 32'd42, 32'd0, 32'hFFFF_FFFF, SPEC_LAT);
    bus.flush = 1'b1;
    checkOutput();
    bus.flush = 1'b0;

    // Flush a divu at N+10: IDLE at N+11, no out_valid, result untouched.
    acceptOnly(OP_DIVU, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    checkVal("flush/busy", 32'(bus.busy), 32'd0);
    checkVal("flush/in_ready", 32'(bus.in_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.out_valid === 1'b1) seen++;
      @(posedge clk);
      #1;
    end
    checkVal("flush/no-out_valid", 32'(seen), 32'd0);
    checkVal("flush/result-kept", bus.result, lastResult);
    applyStimulus("mul3x4", OP_MUL, 32'd3, 32'd4, 32'h0000_000C, MUL_LAT);
    checkOutput();

    // Non-one-hot op and flush alongside in_valid are both ignored.
    bus.in_valid  = 1'b1;
    bus.op_onehot = 8'h03;
    bus.rs1_val   = 32'd6;
    bus.rs2_val   = 32'd7;
    @(posedge clk);
    #1;
    bus.op_onehot = 8'h00;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    checkVal("badop/busy", 32'(bus.busy), 32'd0);
    checkVal("badop/in_ready", 32'(bus.in_ready), 32'd1);
    bus.in_valid  = 1'b1;
    bus.op_onehot = OP_DIVU;
    bus.flush     = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    checkVal("flushaccept/busy", 32'(bus.busy), 32'd0);
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.out_valid === 1'b1) seen++;
      @(posedge clk);
      #1;
    end
    checkVal("ignored/no-out_valid", 32'(seen), 32'd0);

    // Random requests checked against the native-arithmetic model.
    for (int i = 0; i < 12; i++) begin
      k = int'($urandom_range(7, 0));
      a = $urandom;
      b = $urandom;
      if (i == 3) b = 32'h0;
      if (i == 5) b = 32'd1;
      if (i == 7) a = 32'h8000_0000;
      refModel(k, a, b, r, lat);
      applyStimulus($sformatf("rand%0d-op%0d", i, k), 8'(1 << k), a, b, r, lat);
      checkOutput();
    end

    // Asynchronous reset at N+5 of a divide, mid-cycle.
    acceptOnly(OP_DIV, 32'd1000, 32'd7);
    repeat (4) @(posedge clk);
    #1;
    #2 rst_n = 1'b0;
    #1;
    checkVal("midreset/busy", 32'(bus.busy), 32'd0);
    checkVal("midreset/out_valid", 32'(bus.out_valid), 32'd0);
    checkVal("midreset/result", bus.result, 32'h0);
    checkVal("midreset/in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus("divu9/3", OP_DIVU, 32'd9, 32'd3, 32'h0000_0003, DIV_LAT);
    checkOutput();

    checkVal("scoreboard-drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
